alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute-stage successor to the 2-bit-OP ALU control decoder. Decodes OP/func3/func7 into an extended
//  4-bit ALU code, runs the operation, and returns a registered result over a valid/ready handshake.
//  Single-cycle ops take 1 cycle. Optional M-extension ops (MUL, DIVU, REMU) are iterative.
//  Sits between the decode stage and the writeback/branch logic of the multi-cycle core.
// PARAMETERS
//  XLEN      32  operand/result width; power of two, >=8
//  ENABLE_M  1   1: func7=1 ops legal (MUL/DIVU/REMU); 0: those encodings are illegal
// PORTS
//  clk        in   1     single clock, rising edge
//  rst        in   1     synchronous, active-high reset
//  in_valid   in   1     op/func3/func7/a/b valid this cycle
//  in_ready   out  1     unit accepts when in_valid&&in_ready at clk edge
//  op         in   2     0 load/store, 1 branch, 2 R-type, 3 reserved
//  func3      in   3     instruction func3
//  func7      in   7     instruction func7
//  a, b       in   XLEN  operands
//  out_valid  out  1     result/zero/illegal valid
//  out_ready  in   1     consumer takes result when out_valid&&out_ready
//  result     out  XLEN  operation result
//  zero       out  1     result==0 (branch compare)
//  illegal    out  1     decoded encoding unsupported; result forced to 0
// BEHAVIOUR
//  Reset: state IDLE, count 0, out_valid=0, result=0, zero=0, illegal=0. Reset mid-op discards the op; no out_valid.
//  ALU codes: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 SLL, 5 SRL, 6 SUB, 7 SLT, 8 SLTU, 9 SRA, 10 MUL, 11 DIVU, 12 REMU, 15 ILL.
//  Decode: op0->ADD; op1->SUB; op3->ILL.
//  op2, func7=0:  f3 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 6 OR, 7 AND.
//  op2, func7=32: f3 0 SUB, 5 SRA; other f3 ILL.
//  op2, func7=1 (ENABLE_M): f3 0 MUL, 5 DIVU, 7 REMU; else ILL. Any other func7 is ILL.
//  Arithmetic: modulo 2^XLEN. Shift amount is b[$clog2(XLEN)-1:0]. SLT signed, SLTU unsigned; both give 0/1.
//  MUL returns the low XLEN bits.
//  Handshake: in_ready = (state==IDLE) && (!out_valid || out_ready). Accept and drain may occur in the same cycle.
//  Output regs hold stable while out_valid && !out_ready. out_valid drops on the drain edge unless a new result loads.
//  FSM IDLE->IDLE: single-cycle or ILL op accepted. result registered at that edge; out_valid=1 next cycle (latency 1).
//  FSM IDLE->MUL: MUL accepted. Shift-add, one bit/cycle, count 0..XLEN-1.
//  FSM IDLE->DIV: DIVU/REMU accepted. Restoring divide, one bit/cycle, count 0..XLEN-1.
//  MUL/DIV->IDLE at count==XLEN-1: load result, out_valid=1, count=0. Latency from accept is XLEN+1 cycles.
//  Divide by zero: DIVU={XLEN{1'b1}}, REMU=a. Completes with the normal latency; illegal=0.
//  ILL: result=0, zero=1, illegal=1, latency 1. No state change beyond the output regs.
//  in_valid while !in_ready: ignored. The producer holds its inputs; the unit does not latch them.
//  zero and illegal are registered with result and share its valid qualifier.
// STRUCTURE
//  Package alu_exec_pkg:
//   - localparams for the 4-bit ALU codes and OP encodings
//   - state encoding IDLE/MUL/DIV
//   - func7 constants F7_BASE=0, F7_ALT=32, F7_M=1
//  Sub-module alu_decode: combinational (op, func3, func7, ENABLE_M) -> alu_code.
//  Single-cycle datapath, iterative mul/div datapath, FSM and output regs live in alu_exec_unit.
// TESTING
//  1. op2/f7=0/f3=0, a=5, b=7 -> next cycle out_valid=1, result=12, zero=0, illegal=0.
//  2. op1, a=b=9 -> result=0, zero=1. Then op2/f7=32/f3=5, a=32'h8000_0000, b=4 -> SRA result=32'hF800_0000.
//  3. op2/f7=1/f3=5, a=100, b=7 -> in_ready=0 for XLEN cycles; out_valid at cycle XLEN+1, result=14.
//     Repeat with f3=7 (REMU) -> result=2. Then b=0 -> DIVU 32'hFFFF_FFFF and REMU a.
//  4. Backpressure: out_ready=0 for 5 cycles after a result -> result held stable, in_ready=0.
//     out_ready=1 together with a new in_valid -> drain and accept in the same cycle.
//  5. rst=1 at count=10 of a DIVU -> next cycle out_valid=0, in_ready=1, no stale result ever appears.
//  6. op2/f7=5/f3=0 -> illegal=1, result=0. With ENABLE_M=0, op2/f7=1/f3=0 -> illegal=1, latency 1.

Source files
------------

// File: rtl/alu_exec_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_exec_pkg : ALU codes, OP/func7 encodings and FSM states           |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
package alu_exec_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_XOR  = 4'd3;
  localparam logic [3:0] ALU_SLL  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_MUL  = 4'd10;
  localparam logic [3:0] ALU_DIVU = 4'd11;
  localparam logic [3:0] ALU_REMU = 4'd12;
  localparam logic [3:0] ALU_ILL  = 4'd15;

  localparam logic [1:0] OP_MEM = 2'd0;
  localparam logic [1:0] OP_BR  = 2'd1;
  localparam logic [1:0] OP_R   = 2'd2;
  localparam logic [1:0] OP_RSV = 2'd3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [6:0] F7_BASE = 7'd0;
  localparam logic [6:0] F7_ALT  = 7'd32;
  localparam logic [6:0] F7_M    = 7'd1;

  function automatic logic is_iterative(input logic [3:0] code);
    return (code == ALU_MUL) || (code == ALU_DIVU) || (code == ALU_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_unit_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_decode : combinational op/func3/func7 -> 4-bit ALU code           |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
module alu_decode
  import alu_exec_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [1:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output logic [3:0] alu_code
);

  always_comb begin
    alu_code = ALU_ILL;
    case (op)
      OP_MEM: alu_code = ALU_ADD;
      OP_BR:  alu_code = ALU_SUB;
      OP_R: begin
        if (func7 == F7_BASE) begin
          case (func3)
            3'd0:    alu_code = ALU_ADD;
            3'd1:    alu_code = ALU_SLL;
            3'd2:    alu_code = ALU_SLT;
            3'd3:    alu_code = ALU_SLTU;
            3'd4:    alu_code = ALU_XOR;
            3'd5:    alu_code = ALU_SRL;
            3'd6:    alu_code = ALU_OR;
            default: alu_code = ALU_AND;
          endcase
        end else if (func7 == F7_ALT) begin
          if (func3 == 3'd0)      alu_code = ALU_SUB;
          else if (func3 == 3'd5) alu_code = ALU_SRA;
        end else if (ENABLE_M && (func7 == F7_M)) begin
          if (func3 == 3'd0)      alu_code = ALU_MUL;
          else if (func3 == 3'd5) alu_code = ALU_DIVU;
          else if (func3 == 3'd7) alu_code = ALU_REMU;
        end
      end
      default: alu_code = ALU_ILL;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_exec_unit : decoded ALU with iterative MUL/DIVU/REMU, valid/ready |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int                c_SHW  = $clog2(XLEN);
  localparam logic [c_SHW-1:0]  c_LAST = c_SHW'(XLEN - 1);

  logic [3:0]      w_code;
  logic [XLEN-1:0] w_alu;
  logic [c_SHW-1:0] w_shamt;
  logic            w_accept, w_done, w_load;
  logic [XLEN-1:0] w_load_val;

  logic [1:0]       r_state;
  logic [c_SHW-1:0] r_count;
  logic [XLEN-1:0]  r_acc, r_mcand, r_mplier;
  logic [XLEN-1:0]  r_rem, r_quo, r_div;
  logic             r_is_rem;
  logic             r_out_valid, r_zero, r_illegal;
  logic [XLEN-1:0]  r_result;

  alu_decode #(.ENABLE_M(ENABLE_M)) u_decode (
    .op       (op),
    .func3    (func3),
    .func7    (func7),
    .alu_code (w_code)
  );

  assign w_shamt = b[c_SHW-1:0];

  always_comb begin
    w_alu = '0;
    case (w_code)
      ALU_AND:  w_alu = a & b;
      ALU_OR:   w_alu = a | b;
      ALU_ADD:  w_alu = a + b;
      ALU_XOR:  w_alu = a ^ b;
      ALU_SLL:  w_alu = a << w_shamt;
      ALU_SRL:  w_alu = a >> w_shamt;
      ALU_SUB:  w_alu = a - b;
      ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_SRA:  w_alu = $unsigned($signed(a) >>> w_shamt);
      default:  w_alu = '0;
    endcase
  end

  // One shift-add step and one restoring-divide step per cycle.
  logic [XLEN-1:0] w_mul_next;
  logic [XLEN:0]   w_rem_sh, w_diff;
  logic            w_qbit;
  logic [XLEN-1:0] w_rem_next, w_quo_next, w_iter_res;

  assign w_mul_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_rem_sh   = {r_rem, r_quo[XLEN-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_div};
  assign w_qbit     = ~w_diff[XLEN];
  assign w_rem_next = w_qbit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
  assign w_quo_next = {r_quo[XLEN-2:0], w_qbit};
  assign w_iter_res = (r_state == S_MUL) ? w_mul_next :
                      (r_is_rem ? w_rem_next : w_quo_next);

  assign in_ready   = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_done     = (r_state != S_IDLE) && (r_count == c_LAST);
  assign w_load     = (w_accept && !is_iterative(w_code)) || w_done;
  assign w_load_val = w_done ? w_iter_res : w_alu;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_is_rem <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_count <= '0;
          if (w_accept && (w_code == ALU_MUL)) begin
            r_state  <= S_MUL;
            r_acc    <= '0;
            r_mcand  <= a;
            r_mplier <= b;
          end else if (w_accept && is_iterative(w_code)) begin
            r_state  <= S_DIV;
            r_rem    <= '0;
            r_quo    <= a;
            r_div    <= b;
            r_is_rem <= (w_code == ALU_REMU);
          end
        end
        S_MUL: begin
          r_acc    <= w_mul_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= w_done ? '0 : r_count + c_SHW'(1);
          if (w_done) r_state <= S_IDLE;
        end
        S_DIV: begin
          r_rem   <= w_rem_next;
          r_quo   <= w_quo_next;
          r_count <= w_done ? '0 : r_count + c_SHW'(1);
          if (w_done) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

  // Output regs hold under backpressure; a new load overrides a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_result    <= w_load_val;
      r_zero      <= (w_load_val == '0);
      r_illegal   <= !w_done && (w_code == ALU_ILL);
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_exec_unit : directed + random checks against a reference model |
// | Revision         : 1.0                                                |
// +----------------------------------------------------------------------+
module tb_alu_exec_unit;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] c_MSB = {1'b1, {(XLEN-1){1'b0}}};

  logic            clk = 1'b0;
  logic            rst, in_valid, out_ready, n_in_valid;
  logic [1:0]      op;
  logic [2:0]      func3;
  logic [6:0]      func7;
  logic [XLEN-1:0] a, b;
  logic            in_ready, out_valid, zero, illegal;
  logic [XLEN-1:0] result;
  logic            n_in_ready, n_out_valid, n_zero, n_illegal;
  logic [XLEN-1:0] n_result;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(XLEN), .ENABLE_M(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .func3(func3), .func7(func7), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal)
  );

  alu_exec_unit #(.XLEN(XLEN), .ENABLE_M(1'b0)) dut_nom (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .op(op), .func3(func3), .func7(func7), .a(a), .b(b),
    .out_valid(n_out_valid), .out_ready(out_ready), .result(n_result),
    .zero(n_zero), .illegal(n_illegal)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {iterative, illegal, result} straight from the instruction rules.
  function automatic logic [XLEN+1:0] model(input logic [1:0] mop, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [XLEN-1:0] x,
                                            input logic [XLEN-1:0] y, input bit en_m);
    logic [XLEN-1:0] r;
    logic ill, it;
    int sh;
    r = '0; ill = 1'b0; it = 1'b0;
    sh = int'(y % XLEN);
    if (mop == 2'd0) r = x + y;
    else if (mop == 2'd1) r = x - y;
    else if (mop == 2'd3) ill = 1'b1;
    else if (f7 == 7'd0) begin
      case (f3)
        3'd0: r = x + y;
        3'd1: r = x << sh;
        3'd2: r = ((x ^ c_MSB) < (y ^ c_MSB)) ? XLEN'(1) : '0;
        3'd3: r = (x < y) ? XLEN'(1) : '0;
        3'd4: r = x ^ y;
        3'd5: r = x >> sh;
        3'd6: r = x | y;
        default: r = x & y;
      endcase
    end else if (f7 == 7'd32 && f3 == 3'd0) r = x - y;
    else if (f7 == 7'd32 && f3 == 3'd5) r = (x >> sh) | (x[XLEN-1] ? ~({XLEN{1'b1}} >> sh) : '0);
    else if (f7 == 7'd1 && en_m && (f3 == 3'd0 || f3 == 3'd5 || f3 == 3'd7)) begin
      it = 1'b1;
      if (f3 == 3'd0) r = x * y;
      else if (f3 == 3'd5) r = (y == '0) ? {XLEN{1'b1}} : x / y;
      else r = (y == '0) ? x : x % y;
    end else ill = 1'b1;
    return {it, ill, r};
  endfunction

  task automatic run_op(input string tag, input logic [1:0] mop, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    logic [XLEN+1:0] m;
    int lat, busy, exp_lat;
    m = model(mop, f3, f7, x, y, 1'b1);
    exp_lat = m[XLEN+1] ? XLEN + 1 : 1;
    chk({tag, ":in_ready"}, XLEN'(in_ready), XLEN'(1));
    op = mop; func3 = f3; func7 = f7; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; busy = 0;
    while (!out_valid && lat < 3 * XLEN) begin
      if (!in_ready) busy++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ":latency"}, XLEN'(lat), XLEN'(exp_lat));
    chk({tag, ":busy"}, XLEN'(busy), XLEN'(exp_lat - 1));
    chk({tag, ":result"}, result, m[XLEN-1:0]);
    chk({tag, ":zero"}, XLEN'(zero), XLEN'(m[XLEN-1:0] == '0));
    chk({tag, ":illegal"}, XLEN'(illegal), XLEN'(m[XLEN]));
  endtask

  initial begin
    logic seen;
    rst = 1'b1; in_valid = 1'b0; n_in_valid = 1'b0; out_ready = 1'b1;
    op = '0; func3 = '0; func7 = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset:out_valid", XLEN'(out_valid), '0);
    chk("reset:result", result, '0);
    chk("reset:zero", XLEN'(zero), '0);
    chk("reset:illegal", XLEN'(illegal), '0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset:in_ready", XLEN'(in_ready), XLEN'(1));

    run_op("t1_add", 2'd2, 3'd0, 7'd0, 32'd5, 32'd7);
    chk("t1_add_const", result, 32'd12);
    run_op("t2_beq", 2'd1, 3'd0, 7'd0, 32'd9, 32'd9);
    chk("t2_beq_zero", XLEN'(zero), XLEN'(1));
    run_op("t2_sra", 2'd2, 3'd5, 7'd32, 32'h8000_0000, 32'd4);
    chk("t2_sra_const", result, 32'hF800_0000);
    run_op("t3_divu", 2'd2, 3'd5, 7'd1, 32'd100, 32'd7);
    chk("t3_divu_const", result, 32'd14);
    run_op("t3_remu", 2'd2, 3'd7, 7'd1, 32'd100, 32'd7);
    chk("t3_remu_const", result, 32'd2);
    run_op("t3_div0", 2'd2, 3'd5, 7'd1, 32'd1234, 32'd0);
    chk("t3_div0_const", result, 32'hFFFF_FFFF);
    run_op("t3_rem0", 2'd2, 3'd7, 7'd1, 32'd1234, 32'd0);
    chk("t3_rem0_const", result, 32'd1234);
    run_op("t3_mul", 2'd2, 3'd0, 7'd1, 32'hFFFF_FFFF, 32'd3);
    chk("t3_mul_const", result, 32'hFFFF_FFFD);
    run_op("t6_badf7", 2'd2, 3'd0, 7'd5, 32'd3, 32'd4);
    run_op("t6_rsv", 2'd3, 3'd0, 7'd0, 32'd3, 32'd4);

    // Backpressure: hold a result for 5 cycles, then drain and accept together.
    @(posedge clk); #1;
    out_ready = 1'b0;
    op = 2'd0; func3 = '0; func7 = '0; a = 32'd3; b = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", XLEN'(out_valid), XLEN'(1));
      chk("t4_hold_result", result, 32'd7);
      chk("t4_hold_in_ready", XLEN'(in_ready), '0);
      @(posedge clk); #1;
    end
    op = 2'd2; func3 = 3'd4; func7 = 7'd0; a = 32'hF0F0_0000; b = 32'h0FF0_1234;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t4_swap_valid", XLEN'(out_valid), XLEN'(1));
    chk("t4_swap_result", result, 32'hFF00_1234);

    // Reset in the middle of a divide.
    op = 2'd2; func3 = 3'd5; func7 = 7'd1; a = 32'd999; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_rst_out_valid", XLEN'(out_valid), '0);
    chk("t5_rst_in_ready", XLEN'(in_ready), XLEN'(1));
    seen = 1'b0;
    repeat (XLEN + 4) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    chk("t5_no_stale", XLEN'(seen), '0);

    // ENABLE_M=0 instance: M encodings are illegal with latency 1.
    op = 2'd2; func3 = 3'd0; func7 = 7'd1; a = 32'd6; b = 32'd7; n_in_valid = 1'b1;
    chk("t6_nom_in_ready", XLEN'(n_in_ready), XLEN'(1));
    @(posedge clk); #1;
    n_in_valid = 1'b0;
    chk("t6_nom_valid", XLEN'(n_out_valid), XLEN'(1));
    chk("t6_nom_illegal", XLEN'(n_illegal), XLEN'(model(op, func3, func7, a, b, 1'b0) >> XLEN));
    chk("t6_nom_result", n_result, '0);
    chk("t6_nom_zero", XLEN'(n_zero), XLEN'(1));

    for (int i = 0; i < 40; i++) begin
      logic [1:0] rop;
      logic [2:0] rf3;
      logic [6:0] rf7;
      logic [XLEN-1:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      rf3 = 3'($urandom);
      case ($urandom_range(0, 3))
        0: rf7 = 7'd0;
        1: rf7 = 7'd32;
        2: rf7 = 7'd1;
        default: rf7 = 7'($urandom);
      endcase
      ra = $urandom;
      rb = ($urandom_range(0, 1) == 0) ? $urandom : XLEN'($urandom_range(0, 40));
      run_op("rand", rop, rf3, rf7, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
